bsg_bladerunner_rom_reader: RTL
===============================

Name: bsg_bladerunner_rom_reader

Overview:
- Manycore-side initiator that reads the whole bladerunner configuration ROM over the network and caches it locally.
- The host or a tile raises start_i. The block issues one load per ROM word to the ROM's coordinates and collects the returned words by load ID, in any order. It then holds them in a local register array and asserts done_o.
- Sits beside the manycore endpoint's out/returned ports, at the opposite end of the link from the ROM responder.

Parameters:
- rom_width_p, 32, ROM word width; must be <= data_width_p.
- rom_els_p, 32, number of ROM words fetched per pass.
- addr_width_p, 28, manycore EPA word-address width.
- data_width_p, 32, manycore link data width.
- x_cord_width_p, 4, X coordinate width.
- y_cord_width_p, 4, Y coordinate width.
- load_id_width_p, 5, load ID width; must be >= clog2(rom_els_p).
- max_out_credits_p, 4, maximum outstanding loads.
- base_addr_p, 0, EPA of ROM word 0.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- rom_x_i  in  x_cord_width_p  ROM X coordinate (static)
- rom_y_i  in  y_cord_width_p  ROM Y coordinate (static)
- start_i  in  1  begin a read pass; sampled only in IDLE or DONE
- req_v_o  out  1  load request valid
- req_addr_o  out  addr_width_p  base_addr_p + word index
- req_x_o  out  x_cord_width_p  equals rom_x_i
- req_y_o  out  y_cord_width_p  equals rom_y_i
- req_load_id_o  out  load_id_width_p  word index, zero-extended
- req_ready_i  in  1  endpoint accepts the request this cycle
- resp_v_i  in  1  returned load valid
- resp_data_i  in  data_width_p  returned data
- resp_load_id_i  in  load_id_width_p  returned load ID
- resp_yumi_o  out  1  response consumed
- rd_addr_i  in  clog2(rom_els_p)  local read index
- rd_data_o  out  rom_width_p  cached word; combinational from rd_addr_i
- busy_o  out  1  in ISSUE or DRAIN
- done_o  out  1  in DONE
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - state = IDLE; all counters 0; credits = max_out_credits_p.
  - Valid bits and data array cleared to 0.
  - Outputs: req_v_o = 0, busy_o = 0, done_o = 0, err_o = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE or DONE with start_i = 1 -> ISSUE next cycle:
  - issue_idx = 0, rx_cnt = 0, credits = max.
  - All valid bits cleared; err_o cleared. Data contents are left as they are.
- ISSUE:
  - req_v_o = (credits != 0). The request is stable until req_ready_i.
  - Handshake is req_v_o & req_ready_i: issue_idx increments and credits decrement.
  - When the handshake occurs with issue_idx == rom_els_p-1, go to DRAIN.
  - req_v_o never depends combinationally on req_ready_i.
- DRAIN:
  - req_v_o = 0.
  - When rx_cnt reaches rom_els_p (including the cycle the final response lands), go to DONE.
- DONE: done_o = 1. The array stays readable until the next start.
- Responses:
  - resp_yumi_o = resp_v_i in every state; responses are never back-pressured.
  - In ISSUE or DRAIN with a valid, in-range, first-time ID:
    - data[id] <= resp_data_i[rom_width_p-1:0]; valid[id] <= 1.
    - rx_cnt++, credits++.
  - Simultaneous issue and response in the same cycle: credits unchanged.
  - Credits never exceed max_out_credits_p.
- Errors (err_o set, response consumed, no array write, rx_cnt unchanged):
  - response in IDLE or DONE;
  - resp_load_id_i >= rom_els_p;
  - duplicate ID (valid[id] already 1).
  - A credit is still returned for a duplicate or out-of-range ID in ISSUE/DRAIN; it saturates at max.
- Reset asserted mid-pass: everything is immediately reset to the reset state. Responses still in flight after reset are flagged as errors (they arrive in IDLE).
- Widths: req_addr_o = addr_width_p'(base_addr_p + issue_idx). issue_idx and rx_cnt are clog2(rom_els_p+1) bits wide.
- Simulation-only assertions:
  - rom_width_p <= data_width_p
  - clog2(rom_els_p) <= load_id_width_p
  - no change to req_v_o or its payload while it is waiting for req_ready_i

Decomposition:
- bsg_bladerunner_rom_reader_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE) as a 2-bit typedef;
  - localparams for index/count widths derived from rom_els_p.
- One sub-module, bsg_bladerunner_rom_reader_credits: up/down credit counter with a saturating return and an empty flag. The FSM and array stay in the top module.

Test Plan:
- In-order pass: rom_els_p = 8, req_ready_i = 1, each response 3 cycles after its request with data 0xA0+id -> 8 requests, addr/id 0..7; done_o after the 8th response; rd_addr_i = 5 gives 0x A5; err_o = 0.
- Credit stall: max_out_credits_p = 4, responses withheld -> exactly 4 handshakes, then req_v_o = 0. Release one response -> one more request the next cycle.
- Out-of-order returns: ids returned 7,3,0,...; one cycle with an issue and a return together -> credits unchanged; final array is correct; done_o = 1.
- Back-pressure: req_ready_i toggles 0/1 -> addr/id held stable while waiting; no skipped or repeated indices.
- Errors: duplicate id 2 during DRAIN, and a response in IDLE -> err_o = 1 and sticky; data[2] keeps its first value. start_i -> err_o = 0.
- Reset mid-pass: reset_n_i pulled low after 3 issues -> req_v_o = 0 and state IDLE asynchronously. A later start_i completes a full pass correctly.

Source files
------------

// File: rtl/bsg_bladerunner_rom_reader_pkg.sv
// Shared types and width helpers for the bladerunner ROM reader.
// Widths are functions of the ROM depth, so they are computed per instance.
package bsg_bladerunner_rom_reader_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Local word index width (at least one bit for a single-word ROM)
  function automatic int unsigned idx_width(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  // Issue/receive counters must be able to hold rom_els_p itself
  function automatic int unsigned cnt_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_bladerunner_rom_reader_credits.sv
// Outstanding-load credit counter: take on issue, saturating give-back on return.
// A simultaneous take and return leaves the count unchanged.
module bsg_bladerunner_rom_reader_credits
  import bsg_bladerunner_rom_reader_pkg::*;
#(
  parameter  int unsigned max_credits_p = 4,
  localparam int unsigned CredW         = cnt_width(max_credits_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             take_i,
  input  logic             return_i,
  output logic [CredW-1:0] credits_o,
  output logic             empty_o
);

  localparam logic [CredW-1:0] MaxCred = CredW'(max_credits_p);

  logic [CredW-1:0] r_credits;
  logic [CredW-1:0] w_credits_n;

  always_comb begin
    w_credits_n = r_credits;
    if (clear_i) begin
      w_credits_n = MaxCred;
    end else if (take_i && !return_i) begin
      w_credits_n = r_credits - CredW'(1);
    end else if (return_i && !take_i && (r_credits != MaxCred)) begin
      w_credits_n = r_credits + CredW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_credits <= MaxCred;
    end else begin
      r_credits <= w_credits_n;
    end
  end

  assign credits_o = r_credits;
  assign empty_o   = (r_credits == '0);

endmodule

// File: rtl/bsg_bladerunner_rom_reader.sv
// Fetches every word of the bladerunner config ROM over the manycore network,
// accepts the returns in any order by load ID and caches them for local reads.
module bsg_bladerunner_rom_reader
  import bsg_bladerunner_rom_reader_pkg::*;
#(
  parameter  int unsigned rom_width_p       = 32,
  parameter  int unsigned rom_els_p         = 32,
  parameter  int unsigned addr_width_p      = 28,
  parameter  int unsigned data_width_p      = 32,
  parameter  int unsigned x_cord_width_p    = 4,
  parameter  int unsigned y_cord_width_p    = 4,
  parameter  int unsigned load_id_width_p   = 5,
  parameter  int unsigned max_out_credits_p = 4,
  parameter  int unsigned base_addr_p       = 0,
  localparam int unsigned IdxW              = idx_width(rom_els_p),
  localparam int unsigned CntW              = cnt_width(rom_els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [x_cord_width_p-1:0]  rom_x_i,
  input  logic [y_cord_width_p-1:0]  rom_y_i,
  input  logic                       start_i,
  output logic                       req_v_o,
  output logic [addr_width_p-1:0]    req_addr_o,
  output logic [x_cord_width_p-1:0]  req_x_o,
  output logic [y_cord_width_p-1:0]  req_y_o,
  output logic [load_id_width_p-1:0] req_load_id_o,
  input  logic                       req_ready_i,
  input  logic                       resp_v_i,
  input  logic [data_width_p-1:0]    resp_data_i,
  input  logic [load_id_width_p-1:0] resp_load_id_i,
  output logic                       resp_yumi_o,
  input  logic [IdxW-1:0]            rd_addr_i,
  output logic [rom_width_p-1:0]     rd_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned                  CredW    = cnt_width(max_out_credits_p);
  localparam logic [CntW-1:0]              LastIdx  = CntW'(rom_els_p - 1);
  localparam logic [CntW-1:0]              ElsCnt   = CntW'(rom_els_p);
  localparam logic [load_id_width_p:0]     ElsId    = (load_id_width_p + 1)'(rom_els_p);
  localparam logic [addr_width_p-1:0]      AddrBase = addr_width_p'(base_addr_p);

  // Reset asserts asynchronously but releases in step with clk_i
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  state_e                 r_state;
  state_e                 w_state_n;
  logic [CntW-1:0]        r_issue_idx;
  logic [CntW-1:0]        r_rx_cnt;
  logic [CntW-1:0]        w_rx_cnt_n;
  logic [rom_els_p-1:0]   r_valid;
  logic [rom_width_p-1:0] r_data [rom_els_p];
  logic                   r_err;

  logic                   w_start;
  logic                   w_active;
  logic                   w_req_v;
  logic                   w_hs;
  logic                   w_in_range;
  logic                   w_dup;
  logic                   w_good;
  logic                   w_bad;
  logic                   w_cred_return;
  logic                   w_cred_empty;
  logic [CredW-1:0]       w_credits;
  logic [IdxW-1:0]        w_idx;
  logic [rom_width_p-1:0] w_resp_word;

  assign w_idx       = resp_load_id_i[IdxW-1:0];
  assign w_resp_word = resp_data_i[rom_width_p-1:0];
  assign w_in_range  = ({1'b0, resp_load_id_i} < ElsId);
  assign w_dup       = w_in_range && r_valid[w_idx];
  assign w_hs        = w_req_v && req_ready_i;

  // A response only counts once, in-range, and while a pass is running
  assign w_good        = resp_v_i && w_active && w_in_range && !w_dup;
  assign w_bad         = resp_v_i && !(w_active && w_in_range && !w_dup);
  assign w_cred_return = resp_v_i && w_active;
  assign w_rx_cnt_n    = r_rx_cnt + CntW'(w_good);

  always_comb begin
    w_state_n = r_state;
    w_start   = 1'b0;
    w_active  = 1'b0;
    w_req_v   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_start = start_i;
        if (start_i) w_state_n = S_ISSUE;
      end
      S_ISSUE: begin
        w_active = 1'b1;
        busy_o   = 1'b1;
        w_req_v  = !w_cred_empty;
        if (w_hs && (r_issue_idx == LastIdx)) w_state_n = S_DRAIN;
      end
      S_DRAIN: begin
        w_active = 1'b1;
        busy_o   = 1'b1;
        if (w_rx_cnt_n == ElsCnt) w_state_n = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        w_start = start_i;
        if (start_i) w_state_n = S_ISSUE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_issue_idx <= '0;
      r_rx_cnt    <= '0;
      r_valid     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_err   <= w_bad || (r_err && !w_start);
      if (w_start) begin
        r_issue_idx <= '0;
        r_rx_cnt    <= '0;
        r_valid     <= '0;
      end else begin
        if (w_hs) r_issue_idx <= r_issue_idx + CntW'(1);
        r_rx_cnt <= w_rx_cnt_n;
        if (w_good) r_valid[w_idx] <= 1'b1;
      end
    end
  end

  // Contents survive a new start; only the valid bits are cleared then
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < int'(rom_els_p); i++) r_data[i] <= '0;
    end else if (w_good) begin
      r_data[w_idx] <= w_resp_word;
    end
  end

  bsg_bladerunner_rom_reader_credits #(
    .max_credits_p(max_out_credits_p)
  ) u_credits (
    .clk_i    (clk_i),
    .reset_n_i(w_rst_n),
    .clear_i  (w_start),
    .take_i   (w_hs),
    .return_i (w_cred_return),
    .credits_o(w_credits),
    .empty_o  (w_cred_empty)
  );

  assign req_v_o       = w_req_v;
  assign req_addr_o    = AddrBase + addr_width_p'(r_issue_idx);
  assign req_x_o       = rom_x_i;
  assign req_y_o       = rom_y_i;
  assign req_load_id_o = load_id_width_p'(r_issue_idx);
  assign resp_yumi_o   = resp_v_i;
  assign rd_data_o     = r_data[rd_addr_i];
  assign err_o         = r_err;

  if (rom_width_p > data_width_p) begin : g_bad_rom_width
    $error("rom_width_p must not exceed data_width_p");
  end
  if (IdxW > load_id_width_p) begin : g_bad_id_width
    $error("load_id_width_p too narrow to name every ROM word");
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (!w_rst_n)
    (req_v_o && !req_ready_i) |=> (req_v_o && $stable(req_addr_o) &&
      $stable(req_load_id_o) && $stable(req_x_o) && $stable(req_y_o)))
    else $error("request changed while waiting for ready");

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!w_rst_n)
    int'(w_credits) <= int'(max_out_credits_p))
    else $error("credit count above maximum");

endmodule
